// File: rtl/cam_config_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cam_config_seq                                                |
// | Purpose  : Walks a camera register table held in an external synchronous |
// |            ROM after a power-on delay. Each entry becomes one SCCB       |
// |            register write. Delay and end markers are honoured, and       |
// |            NACKed writes are retried. Completion or failure is reported. |
// | Ports    : clk, rst         - clock, synchronous active-high reset       |
// |            start            - restart pulse (honoured in DONE/FAIL only) |
// |            rom_addr/rom_data- table index out, {reg,value} back 1 cy    |
// |            sccb_addr/value  - register write payload to SCCB master     |
// |            sccb_write       - 1-cycle write request                     |
// |            sccb_busy/ack    - master busy, master status (1 = NACK)     |
// |            cfg_busy/done/error, err_index - sequencer status            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cam_config_seq #(
  parameter logic [19:0] POR_CYCLES = 20'hFFFFF,
  parameter logic [15:0] DELAY_UNIT = 16'd50000,
  parameter int          ROM_AW     = 8,
  parameter int          MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_value,
  output logic              sccb_write,
  input  logic              sccb_busy,
  input  logic              sccb_ack,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ROM_AW-1:0] err_index
);

  localparam int                RTRY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTRY_W-1:0] C_MAX_RETRY = RTRY_W'(MAX_RETRY);
  localparam logic [23:0]       C_POR_LAST  = 24'(POR_CYCLES) - 24'd1;
  localparam logic [ROM_AW-1:0] C_LAST_ADDR = '1;

  typedef enum logic [3:0] {
    S_POR_WAIT    = 4'd0,
    S_FETCH       = 4'd1,
    S_DECODE      = 4'd2,
    S_ISSUE       = 4'd3,
    S_WAIT_ACCEPT = 4'd4,
    S_WAIT_DONE   = 4'd5,
    S_PAUSE       = 4'd6,
    S_ADVANCE     = 4'd7,
    S_DONE        = 4'd8,
    S_FAIL        = 4'd9
  } state_t;

  state_t            r_state;
  logic [23:0]       r_cnt;    // shared by the power-on wait and delay entries
  logic [RTRY_W-1:0] r_retry;

  logic        w_is_end;
  logic        w_is_delay;
  logic [23:0] w_delay_len;

  assign w_is_end    = (rom_data == 16'hFFFF);
  assign w_is_delay  = (rom_data[15:8] == 8'hFE);
  // 8-bit count times 16-bit unit fits exactly in 24 bits
  assign w_delay_len = 24'(rom_data[7:0]) * 24'(DELAY_UNIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_POR_WAIT;
      r_cnt      <= '0;
      r_retry    <= '0;
      rom_addr   <= '0;
      sccb_addr  <= '0;
      sccb_value <= '0;
      sccb_write <= 1'b0;
      cfg_busy   <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
      err_index  <= '0;
    end else begin
      sccb_write <= 1'b0;
      case (r_state)
        S_POR_WAIT: begin
          if (r_cnt == C_POR_LAST) begin
            r_cnt    <= '0;
            rom_addr <= '0;
            r_state  <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end

        // rom_data for the current rom_addr lands at the end of this cycle
        S_FETCH: r_state <= S_DECODE;

        S_DECODE: begin
          if (w_is_end) begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_is_delay) begin
            r_cnt   <= w_delay_len;
            r_state <= (w_delay_len == 24'd0) ? S_ADVANCE : S_PAUSE;
          end else begin
            sccb_addr  <= rom_data[15:8];
            sccb_value <= rom_data[7:0];
            r_retry    <= '0;
            // Master already idle: fire now instead of spending a cycle in ISSUE
            if (!sccb_busy) begin
              sccb_write <= 1'b1;
              r_state    <= S_WAIT_ACCEPT;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (!sccb_busy) begin
            sccb_write <= 1'b1;
            r_state    <= S_WAIT_ACCEPT;
          end
        end

        S_WAIT_ACCEPT: begin
          if (sccb_busy) r_state <= S_WAIT_DONE;
        end

        // The master clears its status one cycle after idling, so the
        // ack must be judged on the very first idle cycle.
        S_WAIT_DONE: begin
          if (!sccb_busy) begin
            if (!sccb_ack) begin
              r_state <= S_ADVANCE;
            end else if (r_retry != C_MAX_RETRY) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_ISSUE;
            end else begin
              cfg_error <= 1'b1;
              err_index <= rom_addr;
              cfg_busy  <= 1'b0;
              r_state   <= S_FAIL;
            end
          end
        end

        // Loaded with a non-zero length; stays here exactly that many cycles
        S_PAUSE: begin
          if (r_cnt == 24'd1) begin
            r_state <= S_ADVANCE;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end

        // Running off the end of the table counts as an end marker
        S_ADVANCE: begin
          if (rom_addr == C_LAST_ADDR) begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            r_state  <= S_FETCH;
          end
        end

        S_DONE, S_FAIL: begin
          if (start) begin
            r_cnt     <= '0;
            rom_addr  <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= '0;
            cfg_busy  <= 1'b1;
            r_state   <= S_POR_WAIT;
          end
        end

        default: r_state <= S_POR_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cam_config_seq.md
Name: cam_config_seq

Overview:
- Upstream sequencer for the camera's SCCB register-write master.
- After reset, or on request, it waits a power-on delay, then walks a register table held in an external synchronous ROM.
- It issues one SCCB write per entry, honouring delay and end markers, and retries entries that get a NACK.
- It reports completion or failure to the camera capture logic.

Parameters:
- POR_CYCLES, 20'hFFFFF: clock cycles to wait after reset or start before the first SCCB write (~10.5 ms at 100 MHz).
- DELAY_UNIT, 16'd50000: clock cycles per unit of a delay entry (0.5 ms at 100 MHz).
- ROM_AW, 8: ROM address width; the table holds at most 2^ROM_AW entries.
- MAX_RETRY, 2: extra attempts per entry after a NACK, so each entry gets at most MAX_RETRY+1 attempts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  1-cycle pulse; restarts the sequence from entry 0, honoured only in DONE or FAIL
- rom_addr  out  ROM_AW  table index presented to the ROM
- rom_data  in  16  {reg_addr[15:8], reg_value[7:0]}, valid 1 cycle after rom_addr
- sccb_addr  out  8  register address to the SCCB master
- sccb_value  out  8  register value to the SCCB master
- sccb_write  out  1  1-cycle write request
- sccb_busy  in  1  SCCB master busy
- sccb_ack  in  1  SCCB master status; 1 = NACK seen during the transaction
- cfg_busy  out  1  high in every state except DONE and FAIL
- cfg_done  out  1  table completed with no failure; held until start or rst
- cfg_error  out  1  an entry exhausted its retries; held until start or rst
- err_index  out  ROM_AW  index of the failing entry; valid while cfg_error is high

Behaviour:
- Registered outputs only; all outputs come from flops.
- Reset values: state=POR_WAIT, rom_addr=0, sccb_write=0, sccb_addr=0, sccb_value=0, cfg_done=0, cfg_error=0, err_index=0. cfg_busy=1.
- Table encoding:
  - reg_addr=8'hFF and value=8'hFF is the END marker.
  - reg_addr=8'hFE is a DELAY entry of value*DELAY_UNIT cycles; value=0 means no wait.
  - Any other pair is an SCCB write.
- States and transitions:
  - POR_WAIT: count 0..POR_CYCLES-1, then go to FETCH with rom_addr=0.
  - FETCH: one cycle for ROM latency, then go to DECODE.
  - DECODE:
    - END: go to DONE with cfg_done=1.
    - DELAY: load the counter, go to PAUSE.
    - Otherwise: latch sccb_addr and sccb_value, clear the retry counter, go to ISSUE.
  - ISSUE: wait for sccb_busy=0, then assert sccb_write for exactly 1 cycle and go to WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for sccb_busy=1, then go to WAIT_DONE. sccb_write is never re-asserted while waiting.
  - WAIT_DONE: on the first cycle sccb_busy=0, sample sccb_ack. The SCCB master clears its status one cycle after going idle, so it must be sampled on exactly this cycle.
    - ack=0: go to ADVANCE.
    - ack=1 and retries<MAX_RETRY: increment retries, go to ISSUE with the same addr and value.
    - ack=1 and retries=MAX_RETRY: set cfg_error=1 and err_index=rom_addr, go to FAIL.
  - PAUSE: count the full delay, then go to ADVANCE.
  - ADVANCE: increment rom_addr, go to FETCH.
    - If rom_addr was already 2^ROM_AW-1, do not wrap; treat it as END and go to DONE.
  - DONE / FAIL: idle. start returns to POR_WAIT, clears cfg_done, cfg_error and err_index, and sets rom_addr=0.
- Delay counter width: ROM value (8 bit) times DELAY_UNIT (16 bit) needs a 24-bit counter; no overflow is allowed.
- start outside DONE/FAIL is ignored.
- rst mid-transaction: the sequencer returns to POR_WAIT immediately; a write already accepted by the SCCB master completes on the bus but is not tracked. POR_WAIT covers its duration.
- Minimum write-to-write spacing: ISSUE cannot fire until sccb_busy is low, so back-to-back entries never overlap.
- cfg_done and cfg_error are never both 1.

Test Plan:
- Table {12/80, 11/01, FF/FF} with an SCCB model (busy 40 cycles, ack=0); POR_CYCLES=16 -> first sccb_write at cycle 18 after rst release (16 POR + FETCH + DECODE); writes 0x12=0x80 then 0x11=0x01; cfg_done=1; exactly 2 write pulses.
- Table {FE/03, 3A/04, FF/FF} with DELAY_UNIT=10 -> gap of ≥30 cycles between entering PAUSE and the 0x3A write; cfg_done=1.
- Model NACKs the first 2 attempts of entry 1 (MAX_RETRY=2) -> entry 1 is written 3 times, the sequence completes, cfg_error=0.
- Model NACKs entry 2 always -> 3 attempts, then cfg_error=1, err_index=2, cfg_done=0, no further writes; a start pulse clears the flags and replays from entry 0 after POR.
- Assert rst while WAIT_DONE is active and busy is high -> next cycle cfg_busy=1, rom_addr=0, sccb_write=0; no write until POR expires.
- Table with no END marker, ROM_AW=2 -> 4 writes, then cfg_done=1; rom_addr stays at 3; start during the sequence is ignored.
